// File: rtl/apb_cmd_master.sv
// apb_cmd_master: valid/ready command stream to single APB3 transfers with wait-state timeout
module apb_cmd_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

    state_e            state_q, state_d;
    logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d, rdata_q, rdata_d;
    logic              rvalid_q, rvalid_d, rerr_q, rerr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));
    assign cmd_ready   = (state_q == IDLE);
    assign PSEL        = psel_q;
    assign PENABLE     = penable_q;
    assign PWRITE      = pwrite_q;
    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign rsp_valid   = rvalid_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = rerr_q;

    // Next-state and registered-output decode; every field holds unless its state changes it
    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        rdata_d   = rdata_q;
        rvalid_d  = rvalid_q;
        rerr_d    = rerr_q;
        cnt_d     = cnt_q;
        case (state_q)
            IDLE: if (cmd_valid) begin
                paddr_d  = cmd_addr;
                pwrite_d = cmd_write;
                pwdata_d = cmd_write ? cmd_wdata : '0;
                psel_d   = 1'b1;
                state_d  = SETUP;
            end
            SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ACCESS;
            end
            ACCESS: if (PREADY || timeout_hit) begin
                psel_d    = 1'b0;
                penable_d = 1'b0;
                rvalid_d  = 1'b1;
                rerr_d    = PREADY ? PSLVERR : 1'b1;
                rdata_d   = (PREADY && !pwrite_q) ? PRDATA : '0;
                state_d   = RESP;
            end else begin
                cnt_d = &cnt_q ? cnt_q : cnt_q + CW'(1);
            end
            RESP: if (rsp_ready) begin
                rvalid_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any transfer in flight
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= IDLE;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rdata_q   <= '0;
            rvalid_q  <= 1'b0;
            rerr_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            rdata_q   <= rdata_d;
            rvalid_q  <= rvalid_d;
            rerr_q    <= rerr_d;
            cnt_q     <= cnt_d;
        end
    end
endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- APB initiator. Converts a simple valid/ready command stream (addr, write flag, wdata) into single APB3 transfers, and returns a response stream (rdata, error).
- Drives APB peripherals such as the GPIO block (MR at 0x40040000, DR at 0x40040004) from a bus bridge, debug port or DMA front end.
- One transfer outstanding at a time, with a wait-state timeout.

Parameters:
ADDR_W, 32, width of cmd_addr/PADDR
DATA_W, 32, width of data paths
TIMEOUT, 16, max ACCESS cycles with PREADY low before forced error; 0 disables timeout

Ports:
PCLK  input  1  clock; single clock domain; all logic on rising edge
PRESETn  input  1  reset, asynchronous assert, active-low
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted when cmd_valid&cmd_ready at rising edge
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  target address
cmd_wdata  input  DATA_W  write data (ignored for reads)
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid&rsp_ready at rising edge
rsp_rdata  output  DATA_W  read data; 0 for writes and error-by-timeout
rsp_err  output  1  PSLVERR sampled, or timeout
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PWRITE  output  1  APB direction
PADDR  output  ADDR_W  APB address
PWDATA  output  DATA_W  APB write data
PRDATA  input  DATA_W  APB read data
PREADY  input  1  APB ready (tie 1 for zero-wait slaves)
PSLVERR  input  1  APB error, valid with PREADY in ACCESS

Behaviour:
- Reset (PRESETn low, any time, asynchronous): state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err, timeout counter all 0. cmd_ready=1 after reset release. A transfer in flight is abandoned without a response.
- All APB outputs and rsp_* come from registers; no combinational path from PRDATA/PREADY to outputs.
- FSM states:
  - IDLE: cmd_ready=1, PSEL=0, PENABLE=0. On cmd_valid, latch cmd_write/cmd_addr/cmd_wdata into PWRITE/PADDR/PWDATA, then go to SETUP. PWDATA is loaded with 0 for reads.
  - SETUP: PSEL=1, PENABLE=0, exactly one cycle, then go to ACCESS. The counter clears.
  - ACCESS: PSEL=1, PENABLE=1.
    - If PREADY=1: rsp_rdata=PWRITE?0:PRDATA, rsp_err=PSLVERR, rsp_valid<=1, go to RESP.
    - Else if TIMEOUT!=0 and counter==TIMEOUT-1: rsp_rdata=0, rsp_err=1, rsp_valid<=1, go to RESP.
    - Else counter+1 and stay in ACCESS.
  - RESP: PSEL=0, PENABLE=0, cmd_ready=0. Hold rsp_* stable while rsp_valid&!rsp_ready. On rsp_ready, rsp_valid<=0 and go to IDLE.
- cmd_ready is 0 in SETUP, ACCESS and RESP. Commands presented then stall (backpressure); they are never dropped.
- PADDR, PWRITE and PWDATA are stable from SETUP through the end of ACCESS. They keep their last value in RESP/IDLE and never glitch.
- Latency: command accepted at edge N → SETUP cycle N+1 → ACCESS cycle N+2. With PREADY=1 there, rsp_valid is high in cycle N+3. With k wait states, rsp_valid is high in cycle N+3+k.
- Throughput: with rsp_ready tied 1, back-to-back commands take 4 cycles each (IDLE, SETUP, ACCESS, RESP).
- Timeout bound: ACCESS lasts at most TIMEOUT cycles. A PREADY arriving in the same cycle as the timeout wins: normal completion, error = PSLVERR.
- PSLVERR is ignored whenever PREADY=0. Width rules: the counter holds at least clog2(TIMEOUT+1) bits and never wraps.

Test Plan:
- Write zero-wait: cmd write 0x40040000 data 0x00000F0F, PREADY=1 → SETUP PSEL=1/PENABLE=0 with PADDR=0x40040000, PWDATA=0x0F0F. ACCESS follows next cycle. rsp_valid 3 cycles after acceptance; rsp_err=0, rsp_rdata=0.
- Read zero-wait: cmd read 0x40040004, slave PRDATA=0x00050000 → PWDATA=0, PWRITE=0, rsp_rdata=0x00050000, rsp_err=0.
- Wait states + error: PREADY low for 3 ACCESS cycles, then high with PSLVERR=1 → PADDR/PWDATA stable throughout, rsp_valid at acceptance+6, rsp_err=1.
- Timeout: TIMEOUT=16, PREADY stuck 0 → exactly 16 ACCESS cycles, then rsp_err=1, rsp_rdata=0, PSEL drops. Also PREADY=1 on the 16th cycle → normal completion.
- Backpressure: rsp_ready=0 for 5 cycles while cmd_valid is held with a second command → rsp_* stable, cmd_ready=0, no new SETUP. After rsp_ready, the second command is accepted in the following IDLE cycle.
- Reset mid-ACCESS: assert PRESETn low between edges → PSEL, PENABLE, rsp_valid go 0 immediately. After release, cmd_ready=1 and the next command runs normally.
